// File: rtl/upcoin_spi_master.sv
// ---------------------------------------------------------------------------
// upcoin_spi_master
//
// SPI host for the uPcoin hashing core. Takes 512-bit padded message blocks
// from on-chip logic and shifts them MSB-first to the core. Between blocks it
// waits for the core's input_ready flag. After the final block it waits for
// done, then clocks the digest back in MSB-first on sdo.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   blk_data/valid/   block handshake; a block is accepted when
//   blk_last/ready    blk_valid && blk_ready
//   hash, hash_valid  digest (held until the next digest) and its 1-cycle pulse
//   busy              message in progress
//   err               1-cycle timeout pulse (constant 0 in the default build)
//   sck, sdi, sdo     SPI link; sck idles low, the core samples sdi on sck rise
//   load              high during the first block of a message
//   block_load        high while a block is being shifted
//   message_load      high from first-block accept until the last block ends
//   input_ready, done core flow-control flags
//
// Build option
//   UPCOIN_SPI_TIMEOUT_EN: bounds the GAP and WAIT_DONE waits to
//   TIMEOUT_CYCLES. On expiry it pulses err, drops the link and returns to
//   IDLE. Without the macro the waits are unbounded and err is tied low.
// ---------------------------------------------------------------------------
module upcoin_spi_master #(
    parameter int BLOCK_BITS     = 512,
    parameter int HASH_BITS      = 256,
    parameter int SCK_DIV        = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BLOCK_BITS-1:0] blk_data,
    input  logic                  blk_valid,
    input  logic                  blk_last,
    output logic                  blk_ready,
    output logic [HASH_BITS-1:0]  hash,
    output logic                  hash_valid,
    output logic                  busy,
    output logic                  err,
    output logic                  sck,
    output logic                  sdi,
    input  logic                  sdo,
    output logic                  load,
    output logic                  block_load,
    output logic                  message_load,
    input  logic                  input_ready,
    input  logic                  done
);
    localparam int BCW = $clog2(BLOCK_BITS) + 1;
    localparam int DW  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    // WAIT_BLK is kept in the encoding but never entered; it decodes back to IDLE.
    typedef enum logic [2:0] {IDLE, WAIT_BLK, SHIFT, GAP, WAIT_DONE, READ, FINISH} state_t;
    state_t state, state_next;

    // The shift register carries the outgoing block. During READ it is reused
    // to collect the digest in its low HASH_BITS bits.
    logic [BLOCK_BITS-1:0] shreg;
    logic [BCW-1:0]        bit_cnt;
    logic [DW-1:0]         div_cnt;
    logic                  blk_last_q;
    logic                  idle_rdy;   // keeps blk_ready low while reset is held
    logic                  accept;
    logic                  half_end;
    logic                  last_bit;
    logic                  last_hbit;
    logic                  timeout;

    assign half_end  = (div_cnt == DW'(SCK_DIV - 1));
    assign last_bit  = (bit_cnt == BCW'(BLOCK_BITS - 1));
    assign last_hbit = (bit_cnt == BCW'(HASH_BITS - 1));

    // sdi follows the register MSB only while a block is on the wire.
    assign sdi = block_load & shreg[BLOCK_BITS-1];

`ifdef UPCOIN_SPI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          to_run;

    assign to_run  = (state == WAIT_DONE && !done) || (state == GAP && !input_ready);
    assign timeout = to_run && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            to_cnt <= '0;
        else if (to_run && !timeout)
            to_cnt <= to_cnt + 1'b1;
        else
            to_cnt <= '0;
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        blk_ready  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                blk_ready = idle_rdy;
                if (idle_rdy && blk_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT:
                if (half_end && sck && last_bit)
                    state_next = blk_last_q ? WAIT_DONE : GAP;
            // done is deliberately not looked at here; only input_ready moves GAP on.
            GAP: begin
                blk_ready = input_ready;
                if (input_ready && blk_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            WAIT_DONE:
                if (done)
                    state_next = READ;
            READ:
                if (half_end && !sck && last_hbit)
                    state_next = FINISH;
            FINISH:
                state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
        if (timeout)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (accept)
            shreg <= blk_data;
        else if (state == SHIFT && sck && half_end)
            shreg <= {shreg[BLOCK_BITS-2:0], 1'b0};
        else if (state == READ && sck && half_end)
            shreg <= {shreg[BLOCK_BITS-2:0], sdo};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck          <= 1'b0;
            load         <= 1'b0;
            block_load   <= 1'b0;
            message_load <= 1'b0;
            busy         <= 1'b0;
            hash         <= '0;
            hash_valid   <= 1'b0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            blk_last_q   <= 1'b0;
            idle_rdy     <= 1'b0;
`ifdef UPCOIN_SPI_TIMEOUT_EN
            err          <= 1'b0;
`endif
        end else begin
            hash_valid <= 1'b0;
            idle_rdy   <= (state_next == IDLE);
`ifdef UPCOIN_SPI_TIMEOUT_EN
            err        <= timeout;
`endif
            if (timeout) begin
                sck          <= 1'b0;
                load         <= 1'b0;
                block_load   <= 1'b0;
                message_load <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    IDLE, GAP:
                        if (accept) begin
                            blk_last_q <= blk_last;
                            sck        <= 1'b0;
                            bit_cnt    <= '0;
                            div_cnt    <= '0;
                            block_load <= 1'b1;
                            if (state == IDLE) begin
                                busy         <= 1'b1;
                                message_load <= 1'b1;
                                load         <= 1'b1;
                            end
                        end
                    // Each bit: sck low SCK_DIV clocks, then high SCK_DIV clocks.
                    SHIFT: begin
                        div_cnt <= half_end ? '0 : div_cnt + 1'b1;
                        if (half_end) begin
                            sck <= ~sck;
                            if (sck) begin
                                if (last_bit) begin
                                    block_load <= 1'b0;
                                    load       <= 1'b0;
                                    if (blk_last_q)
                                        message_load <= 1'b0;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    // The first read pulse starts rising on the same edge that sees done.
                    WAIT_DONE:
                        if (done) begin
                            sck     <= 1'b1;
                            bit_cnt <= '0;
                            div_cnt <= '0;
                        end
                    READ: begin
                        div_cnt <= half_end ? '0 : div_cnt + 1'b1;
                        if (half_end) begin
                            if (sck) begin
                                sck <= 1'b0;
                            end else if (!last_hbit) begin
                                sck     <= 1'b1;
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    FINISH: begin
                        hash       <= shreg[HASH_BITS-1:0];
                        hash_valid <= 1'b1;
                        busy       <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_upcoin_spi_master.sv
module tb_upcoin_spi_master;
    localparam int BB = 512;
    localparam int HB = 256;
    localparam int SD = 4;
    localparam int TO = 1000;

    logic          clk = 1'b0;
    logic          reset;
    logic [BB-1:0] blk_data;
    logic          blk_valid;
    logic          blk_last;
    logic          blk_ready;
    logic [HB-1:0] hash;
    logic          hash_valid;
    logic          busy;
    logic          err;
    logic          sck;
    logic          sdi;
    logic          sdo;
    logic          load;
    logic          block_load;
    logic          message_load;
    logic          input_ready;
    logic          done;

    upcoin_spi_master #(
        .BLOCK_BITS(BB), .HASH_BITS(HB), .SCK_DIV(SD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .blk_data(blk_data), .blk_valid(blk_valid),
        .blk_last(blk_last), .blk_ready(blk_ready), .hash(hash), .hash_valid(hash_valid),
        .busy(busy), .err(err), .sck(sck), .sdi(sdi), .sdo(sdo), .load(load),
        .block_load(block_load), .message_load(message_load),
        .input_ready(input_ready), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            nblk;
        logic [BB-1:0] b0;
        logic [BB-1:0] b1;
        logic [BB-1:0] b2;
        logic [HB-1:0] dig;
    } vec_t;

    vec_t          vt[3];
    int            nvec = 0;
    int            nmis = 0;
    logic [BB-1:0] last_cap;

    task automatic chk(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BB-1:0] rnd_blk();
        logic [BB-1:0] r;
        for (int k = 0; k < BB / 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [HB-1:0] rnd_dig();
        logic [HB-1:0] r;
        for (int k = 0; k < HB / 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    // Offer one block, then act as the core's receiver: capture sdi on every
    // sck rise while block_load is high and compare against what was sent.
    task automatic send_block(input logic [BB-1:0] data, input logic last, input logic first);
        logic [BB-1:0] cap;
        int            bl, rises, bad, t;
        logic          psck;
        cap = '0; bl = 0; rises = 0; bad = 0; t = 0;
        blk_data = data; blk_last = last; blk_valid = 1'b1;
        while (!blk_ready && t < 2000) begin tick(); t++; end
        chk("accept_wait", t < 2000, 1);
        tick();
        blk_valid = 1'b0;
        done = 1'b0;
        psck = 1'b0;
        while (block_load && bl < 5000) begin
            bl++;
            if (load !== first || message_load !== 1'b1 || busy !== 1'b1) bad++;
            if (sck && !psck) begin
                cap = {cap[BB-2:0], sdi};
                rises++;
            end
            psck = sck;
            tick();
        end
        last_cap = cap;
        chk("block_data", cap, data);
        chk("block_load_clks", bl, BB * 2 * SD);
        chk("block_bits", rises, BB);
        chk("load_level", bad, 0);
        chk("end_sck_load", {sck, load, block_load}, 0);
        chk("msg_load_after", message_load, !last);
    endtask

    // Hold input_ready low for n clocks in GAP, then raise it together with done.
    task automatic gap(input int n);
        int bad;
        bad = 0;
        input_ready = 1'b0;
        repeat (n) begin
            tick();
            if (blk_ready || block_load || sck) bad++;
        end
        chk("gap_ready_low", bad, 0);
        input_ready = 1'b1;
        done = 1'b1;
        #1;
        chk("gap_ready_high", blk_ready, 1);
    endtask

    // Core side of the digest read: sdo is preloaded with the MSB and moves to
    // the next bit on every sck fall.
    task automatic read_digest(input logic [HB-1:0] dig);
        int   idx, rises, t;
        logic psck;
        idx = HB - 1; rises = 0; t = 0;
        sdo = dig[idx];
        done = 1'b1;
        input_ready = 1'b0;
        psck = sck;
        tick();
        done = 1'b0;
        while (!hash_valid && t < 4000) begin
            if (sck && !psck) rises++;
            if (!sck && psck && idx > 0) begin
                idx--;
                sdo = dig[idx];
            end
            psck = sck;
            tick();
            t++;
        end
        chk("hash_valid_seen", hash_valid, 1);
        chk("hash", hash, dig);
        chk("read_rises", rises, HB);
        tick();
        chk("hash_valid_pulse", hash_valid, 0);
        chk("busy_after", busy, 0);
        chk("blk_ready_idle", blk_ready, 1);
    endtask

    task automatic run_msg(input vec_t v, input int gap_n);
        logic [BB-1:0] b;
        for (int i = 0; i < v.nblk; i++) begin
            b = (i == 0) ? v.b0 : (i == 1) ? v.b1 : v.b2;
            if (i > 0) gap(gap_n);
            send_block(b, i == v.nblk - 1, i == 0);
        end
        read_digest(v.dig);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          rv;
        logic [7:0]    first8;
        logic [BB-1:0] b;
        int            t, rises, bad;
        logic          psck;

        vt[0].nblk = 1;
        vt[0].b0   = {32'h61626380, 416'h0, 64'h18};
        vt[0].b1   = '0;
        vt[0].b2   = '0;
        vt[0].dig  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        vt[1].nblk = 3;
        vt[1].b0   = {64{8'h61}};
        vt[1].b1   = {{56{8'h61}}, 64'h8000000000000000};
        vt[1].b2   = 512'h3c0;
        vt[1].dig  = 256'h2f3d335432c70b580af0e8e1b3674a7c020d683aa5f73aaaedfdc55af904c21c;
        vt[2].nblk = 1;
        vt[2].b0   = rnd_blk();
        vt[2].b1   = '0;
        vt[2].b2   = '0;
        vt[2].dig  = {64{4'hA}};

        reset = 1'b1; blk_data = '0; blk_valid = 1'b0; blk_last = 1'b0;
        sdo = 1'b0; input_ready = 1'b0; done = 1'b0;
        tick(); tick();
        chk("reset_ctrl", {sck, sdi, load, block_load, message_load, blk_ready,
                           hash_valid, busy, err}, 0);
        chk("reset_hash", hash, 0);
        reset = 1'b0;
        tick();
        chk("ready_after_reset", blk_ready, 1);

        for (int i = 0; i < 3; i++) begin
            run_msg(vt[i], 5 + i * 7);
            if (i == 0) begin
                first8 = last_cap[BB-1 -: 8];
                chk("abc_first_byte", first8, 8'h61);
                chk("abc_first_bit", last_cap[BB-1], 0);
            end
        end

        rv.nblk = 2; rv.b0 = rnd_blk(); rv.b1 = rnd_blk(); rv.b2 = '0; rv.dig = rnd_dig();
        run_msg(rv, $urandom_range(20, 1));

        // Stall: input_ready high with no block offered.
        rv.b0 = rnd_blk(); rv.b1 = rnd_blk(); rv.dig = rnd_dig();
        send_block(rv.b0, 1'b0, 1'b1);
        input_ready = 1'b1;
        bad = 0;
        repeat (500) begin
            tick();
            if (block_load || sck || !blk_ready || !message_load) bad++;
        end
        chk("stall_static", bad, 0);
        send_block(rv.b1, 1'b1, 1'b0);
        read_digest(rv.dig);

        // Reset at bit 200 of block 2.
        b = rnd_blk();
        send_block(rnd_blk(), 1'b0, 1'b1);
        gap(3);
        blk_data = b; blk_last = 1'b1; blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0; done = 1'b0;
        rises = 0; t = 0; psck = 1'b0;
        while (rises < 200 && t < 3000) begin
            tick();
            t++;
            if (sck && !psck) rises++;
            psck = sck;
        end
        chk("reach_bit200", rises, 200);
        #2 reset = 1'b1;
        #1;
        chk("midreset_ctrl", {sck, sdi, load, block_load, message_load, blk_ready,
                              hash_valid, busy, err}, 0);
        chk("midreset_hash", hash, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        run_msg(vt[0], 1);

        // Digest never arrives.
        send_block(vt[0].b0, 1'b1, 1'b1);
        bad = 0;
`ifdef UPCOIN_SPI_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            tick();
            if (err || !busy) bad++;
        end
        chk("timeout_early", bad, 0);
        tick();
        chk("timeout_err", err, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_hash", hash, vt[0].dig);
        tick();
        chk("timeout_err_pulse", err, 0);
        chk("timeout_link", {sck, sdi, load, block_load, message_load}, 0);
        chk("timeout_ready", blk_ready, 1);
`else
        for (int i = 0; i < TO + 100; i++) begin
            tick();
            if (err || !busy) bad++;
        end
        chk("no_timeout", bad, 0);
        chk("wait_hash_held", hash, vt[0].dig);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
